commit_trace_queue: RTL and testbench

Parametrised commit-record buffer between the CPU writeback stage and the Difftest commit/trap probes in `core`. It replaces fixed two-stage delay registers on write-enable, destination and data with an in-order FIFO of complete commit records, accepting and emitting up to `NPORT` records per cycle. It also provides the cycle and instruction counters consumed by the trap-event probe.

---
 rtl/commit_trace_queue_pkg.sv | 29 ++
 rtl/commit_trace_queue_if.sv | 34 +++
 rtl/commit_trace_queue.sv | 117 +++++++++++
 tb/tb_commit_trace_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_queue_pkg.sv
// Shared types and helpers for the commit trace queue.
// - commit_rec_t : one complete writeback commit record
// - lead_ones()  : length of the contiguous run of set valid bits from lane 0
package commit_trace_queue_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned MaxNport = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            wen;
        logic [4:0]      wdest;
        logic [XLEN-1:0] wdata;
        logic            skip;
    } commit_rec_t;

    // Lanes after the first clear bit are ignored, so only the leading run counts.
    function automatic logic [1:0] lead_ones(input logic [MaxNport-1:0] valid);
        if (!valid[0]) begin
            return 2'd0;
        end else if (!valid[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

endpackage

// File: rtl/commit_trace_queue_if.sv
// Bus between writeback (master) and the commit trace queue (slave).
// Push side : push_valid, push_rec -> push_ready
// Control   : retire_en, flush
// Commit    : commit_valid, commit_rec (registered)
// Status    : count, cycle_cnt, instr_cnt, overflow
interface commit_trace_queue_if #(
    parameter int unsigned NPORT = 1,
    parameter int unsigned DEPTH = 8
);
    import commit_trace_queue_pkg::*;

    logic [NPORT-1:0]               push_valid;
    commit_rec_t [NPORT-1:0]        push_rec;
    logic                           push_ready;
    logic                           retire_en;
    logic                           flush;
    logic [NPORT-1:0]               commit_valid;
    commit_rec_t [NPORT-1:0]        commit_rec;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic [63:0]                    cycle_cnt;
    logic [63:0]                    instr_cnt;
    logic                           overflow;

    modport master (
        output push_valid, push_rec, retire_en, flush,
        input  push_ready, commit_valid, commit_rec, count, cycle_cnt, instr_cnt, overflow
    );

    modport slave (
        input  push_valid, push_rec, retire_en, flush,
        output push_ready, commit_valid, commit_rec, count, cycle_cnt, instr_cnt, overflow
    );

endinterface

// File: rtl/commit_trace_queue.sv
// In-order FIFO of commit records feeding the Difftest commit/trap probes.
// Accepts and emits up to NPORT records per cycle; outputs are registered.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high; clears all state
//   bus   - commit_trace_queue_if slave modport (push, retire, flush, commit, status)
module commit_trace_queue
    import commit_trace_queue_pkg::*;
#(
    parameter int unsigned NPORT = 1,
    parameter int unsigned DEPTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    commit_trace_queue_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    commit_rec_t             mem_q [DEPTH];
    commit_rec_t             mem_d [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [NPORT-1:0]        commit_valid_q, commit_valid_d;
    commit_rec_t [NPORT-1:0] commit_rec_q, commit_rec_d;
    logic [63:0]             cycle_cnt_q, cycle_cnt_d;
    logic [63:0]             instr_cnt_q, instr_cnt_d;
    logic                    overflow_q, overflow_d;

    logic                    push_ready;
    logic                    any_push;
    logic [MaxNport-1:0]     valid_ext;
    logic [CW-1:0]           n_push;
    logic [CW-1:0]           n_pop;
    logic [CW-1:0]           avail;

    // Free space is judged on the current occupancy only; a same-cycle pop does not help.
    assign push_ready = (count_q <= CW'(DEPTH - NPORT));

    always_comb begin
        valid_ext              = '0;
        valid_ext[NPORT-1:0]   = bus.push_valid;
        any_push               = |bus.push_valid;
        n_push = (any_push && push_ready && !bus.flush) ? CW'(lead_ones(valid_ext)) : '0;
        avail  = (count_q < CW'(NPORT)) ? count_q : CW'(NPORT);
        n_pop  = (bus.retire_en && !bus.flush) ? avail : '0;

        mem_d = mem_q;
        for (int i = 0; i < NPORT; i++) begin
            if (CW'(i) < n_push) begin
                mem_d[wr_ptr_q + PW'(i)] = bus.push_rec[i];
            end
        end

        // Lanes not emitted keep their old record fields; only valid drops.
        for (int i = 0; i < NPORT; i++) begin
            commit_valid_d[i] = (CW'(i) < n_pop);
            commit_rec_d[i]   = commit_valid_d[i] ? mem_q[rd_ptr_q + PW'(i)] : commit_rec_q[i];
        end

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(n_push);
            rd_ptr_d = rd_ptr_q + PW'(n_pop);
            count_d  = count_q + n_push - n_pop;
        end

        overflow_d  = overflow_q | (any_push & ~push_ready);
        cycle_cnt_d = cycle_cnt_q + 64'd1;

        // Credit records in the cycle they are presented on the commit lanes.
        instr_cnt_d = instr_cnt_q;
        for (int i = 0; i < NPORT; i++) begin
            instr_cnt_d = instr_cnt_d + 64'(commit_valid_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            commit_valid_q <= '0;
            commit_rec_q   <= '0;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rec_q   <= commit_rec_d;
            cycle_cnt_q    <= cycle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.push_ready   = push_ready;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rec   = commit_rec_q;
    assign bus.count        = count_q;
    assign bus.cycle_cnt    = cycle_cnt_q;
    assign bus.instr_cnt    = instr_cnt_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed self-checking bench for commit_trace_queue with NPORT=2, DEPTH=8.
module tb_commit_trace_queue;
    import commit_trace_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    commit_trace_queue_if #(.NPORT(2), .DEPTH(8)) bus ();

    commit_trace_queue #(.NPORT(2), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int              checks   = 0;
    int              failures = 0;
    longint unsigned exp_cyc  = 0;
    commit_rec_t     rec_a;
    commit_rec_t     zero_rec;

    function automatic commit_rec_t mk(input int k);
        commit_rec_t r;
        r.pc    = 64'h0000_0000_8000_1000 + 64'(k) * 64'd4;
        r.instr = 32'h0010_0093 + 32'(k);
        r.wen   = 1'b1;
        r.wdest = 5'(k);
        r.wdata = 64'(k) * 64'h101;
        r.skip  = k[0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_cyc++;
    endtask

    task automatic drive(input logic [1:0] v, input commit_rec_t r0, input commit_rec_t r1,
                         input logic ret, input logic fl);
        bus.push_valid  = v;
        bus.push_rec[0] = r0;
        bus.push_rec[1] = r1;
        bus.retire_en   = ret;
        bus.flush       = fl;
    endtask

    initial begin
        zero_rec = '0;
        rec_a       = '0;
        rec_a.pc    = 64'h0000_0000_8000_0000;
        rec_a.instr = 32'h0010_0093;
        rec_a.wen   = 1'b1;
        rec_a.wdest = 5'd1;
        rec_a.wdata = 64'd1;

        reset = 1'b1;
        drive(2'b00, zero_rec, zero_rec, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cyc = 0;

        // Reset state
        check("rst_push_ready", 256'(bus.push_ready), 256'd1);
        check("rst_count", 256'(bus.count), 256'd0);
        check("rst_commit_valid", 256'(bus.commit_valid), 256'd0);
        check("rst_commit_rec", 256'(bus.commit_rec), 256'd0);
        check("rst_cycle", 256'(bus.cycle_cnt), 256'd0);
        check("rst_instr", 256'(bus.instr_cnt), 256'd0);
        check("rst_overflow", 256'(bus.overflow), 256'd0);

        // Single push, retire next cycle, commit presented one cycle later
        drive(2'b01, rec_a, zero_rec, 1'b0, 1'b0);
        step();
        check("t1_count", 256'(bus.count), 256'd1);
        check("t1_no_commit_yet", 256'(bus.commit_valid), 256'd0);
        drive(2'b00, zero_rec, zero_rec, 1'b1, 1'b0);
        step();
        check("t1_commit_valid", 256'(bus.commit_valid), 256'b01);
        check("t1_commit_rec", 256'(bus.commit_rec[0]), 256'(rec_a));
        check("t1_count_after", 256'(bus.count), 256'd0);
        drive(2'b00, zero_rec, zero_rec, 1'b0, 1'b0);
        step();
        check("t1_valid_drop", 256'(bus.commit_valid), 256'd0);
        check("t1_rec_held", 256'(bus.commit_rec[0]), 256'(rec_a));
        check("t1_instr", 256'(bus.instr_cnt), 256'd1);
        check("t1_cycle", 256'(bus.cycle_cnt), 256'(exp_cyc));

        // Fill with dual pushes to full, then overflow
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("fill_ready_at6", 256'(bus.push_ready), 256'd1);
            drive(2'b11, mk(10 + 2 * i), mk(11 + 2 * i), 1'b0, 1'b0);
            step();
        end
        check("fill_count8", 256'(bus.count), 256'd8);
        check("fill_ready0", 256'(bus.push_ready), 256'd0);
        check("fill_ovf_before", 256'(bus.overflow), 256'd0);
        drive(2'b11, mk(90), mk(91), 1'b0, 1'b0);
        step();
        check("ovf_set", 256'(bus.overflow), 256'd1);
        check("ovf_count", 256'(bus.count), 256'd8);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, zero_rec, zero_rec, 1'b1, 1'b0);
            step();
            check("drain_valid", 256'(bus.commit_valid), 256'b11);
            check("drain_rec0", 256'(bus.commit_rec[0]), 256'(mk(10 + 2 * i)));
            check("drain_rec1", 256'(bus.commit_rec[1]), 256'(mk(11 + 2 * i)));
        end
        check("drain_count0", 256'(bus.count), 256'd0);
        check("ovf_sticky", 256'(bus.overflow), 256'd1);

        // Reach count=7: push_ready must be low with only one free entry
        drive(2'b01, mk(20), zero_rec, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, mk(21 + 2 * i), mk(22 + 2 * i), 1'b0, 1'b0);
            step();
        end
        check("c7_count", 256'(bus.count), 256'd7);
        check("c7_ready0", 256'(bus.push_ready), 256'd0);
        drive(2'b00, zero_rec, zero_rec, 1'b1, 1'b0);
        step();
        check("c5_count", 256'(bus.count), 256'd5);
        check("c5_rec0", 256'(bus.commit_rec[0]), 256'(mk(20)));
        check("c5_rec1", 256'(bus.commit_rec[1]), 256'(mk(21)));

        // Flush wins over push and retire
        drive(2'b11, mk(80), mk(81), 1'b1, 1'b1);
        step();
        check("flush_count", 256'(bus.count), 256'd0);
        check("flush_valid", 256'(bus.commit_valid), 256'd0);
        check("flush_ready", 256'(bus.push_ready), 256'd1);
        check("flush_cycle", 256'(bus.cycle_cnt), 256'(exp_cyc));

        // Gap lanes: only a leading run is accepted
        drive(2'b10, mk(70), mk(71), 1'b0, 1'b0);
        step();
        check("gap_count", 256'(bus.count), 256'd0);
        drive(2'b11, mk(30), mk(31), 1'b0, 1'b0);
        step();
        check("dual_count", 256'(bus.count), 256'd2);
        drive(2'b00, zero_rec, zero_rec, 1'b1, 1'b0);
        step();
        check("dual_valid", 256'(bus.commit_valid), 256'b11);
        check("dual_rec0", 256'(bus.commit_rec[0]), 256'(mk(30)));
        check("dual_rec1", 256'(bus.commit_rec[1]), 256'(mk(31)));

        // Wrap-around: push and retire together, records emerge one cycle behind
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, mk(100 + i), zero_rec, 1'b1, 1'b0);
            step();
            check("wrap_count", 256'(bus.count), 256'd1);
            if (i == 0) begin
                check("wrap_first_valid", 256'(bus.commit_valid), 256'd0);
            end else begin
                check("wrap_valid", 256'(bus.commit_valid), 256'b01);
                check("wrap_rec", 256'(bus.commit_rec[0]), 256'(mk(99 + i)));
            end
        end
        drive(2'b00, zero_rec, zero_rec, 1'b1, 1'b0);
        step();
        check("wrap_last_rec", 256'(bus.commit_rec[0]), 256'(mk(119)));
        check("wrap_count0", 256'(bus.count), 256'd0);
        drive(2'b00, zero_rec, zero_rec, 1'b0, 1'b0);
        step();
        check("wrap_idle_valid", 256'(bus.commit_valid), 256'd0);
        check("instr_total", 256'(bus.instr_cnt), 256'd33);
        check("cycle_total", 256'(bus.cycle_cnt), 256'(exp_cyc));

        // Asynchronous reset between edges mid-stream
        drive(2'b11, mk(40), mk(41), 1'b1, 1'b0);
        step();
        drive(2'b11, mk(42), mk(43), 1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_ready", 256'(bus.push_ready), 256'd1);
        check("arst_count", 256'(bus.count), 256'd0);
        check("arst_valid", 256'(bus.commit_valid), 256'd0);
        check("arst_rec", 256'(bus.commit_rec), 256'd0);
        check("arst_cycle", 256'(bus.cycle_cnt), 256'd0);
        check("arst_instr", 256'(bus.instr_cnt), 256'd0);
        check("arst_ovf", 256'(bus.overflow), 256'd0);
        drive(2'b00, zero_rec, zero_rec, 1'b0, 1'b0);
        #2;
        reset   = 1'b0;
        exp_cyc = 0;
        step();
        check("arst_cycle_restart", 256'(bus.cycle_cnt), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
